// File: rtl/odd_seq_sched.sv
// Two-requester burst scheduler around one shared odd-value generator.
// A round-robin pick in IDLE starts a burst; RUN streams len+1 consecutive odd values.
module odd_seq_sched #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_owner,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
  } req_t;

  state_t           state, state_nxt;
  req_t [1:0]       req;
  logic [WIDTH-1:0] cnt;
  logic [LEN_W-1:0] rem;
  logic             owner, rr;
  logic             win, grant, beat, last;

  assign req[0] = '{valid: req0_valid, len: req0_len};
  assign req[1] = '{valid: req1_valid, len: req1_len};

  // rr only breaks ties; a lone requester always wins
  always_comb begin
    win = req[1].valid;
    if (req[0].valid && req[1].valid) win = rr;
  end

  assign grant = (state == IDLE) && (req[0].valid || req[1].valid);
  assign last  = (rem == '0);
  assign beat  = (state == RUN) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)        state_nxt = RUN;
      RUN:     if (beat && last) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Generator state survives across bursts so no value repeats before wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= WIDTH'(1);
      rem   <= '0;
      owner <= 1'b0;
      rr    <= 1'b0;
    end else if (grant) begin
      owner <= win;
      rem   <= req[win].len;
      rr    <= ~win;
    end else if (beat) begin
      cnt <= cnt + WIDTH'(2);
      rem <= rem - LEN_W'(1);
    end
  end

  always_comb begin
    req0_ready = grant && !win;
    req1_ready = grant &&  win;
    out_valid  = (state == RUN);
    out_last   = (state == RUN) && last;
    busy       = (state == RUN);
    out_data   = cnt;
    out_owner  = owner;
  end

endmodule

// File: tb/tb_odd_seq_sched.sv
// Randomized bench for odd_seq_sched against an arithmetic model of the
// odd sequence (next value = base + 2*k mod 2^WIDTH) and round-robin pick.
module tb_odd_seq_sched;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0, rst_n = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic [LEN_W-1:0] req0_len = '0, req1_len = '0;
  logic             req0_ready, req1_ready, out_valid, out_owner, out_last, busy;
  logic [WIDTH-1:0] out_data;

  int n_tests = 0, n_fail = 0;
  int m_cnt = 1, m_rr = 0;

  typedef struct {
    logic v, r;
    logic [WIDTH-1:0] d;
    logic o, l, b, rd0, rd1;
  } smp_t;
  smp_t log_q[$];
  bit   stall_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  odd_seq_sched #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_len(req1_len), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_owner(out_owner),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // All tasks run from the point 1ns after a rising edge.
  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m_cnt = 1; m_rr = 0;
  endtask

  task automatic request(input bit r0, input bit r1, input int l0, input int l1, output int win);
    req0_valid = r0; req1_valid = r1;
    req0_len = LEN_W'(l0); req1_len = LEN_W'(l1);
    win = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        win = (req0_ready && req1_ready) ? 2 : (req1_ready ? 1 : 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  // mode 0: sink always ready, 1: random ready, 2: fixed stall pattern
  task automatic collect(input int mode, output bit done);
    log_q.delete();
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else                out_ready = (i < 5) ? stall_pat[i] : 1'b1;
      #1;
      log_q.push_back('{out_valid, out_ready, out_data, out_owner, out_last, busy, req0_ready, req1_ready});
      if (out_valid && out_ready && out_last) done = 1;
      @(posedge clk); #1;
    end
    out_ready = 0;
  endtask

  task automatic test_reset();
    logic [13:0] rv;
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    #1 rst_n = 0;
    #1 rv = {out_valid, out_last, out_owner, out_data, req0_ready, req1_ready, busy};
    n_tests++;
    if (rv !== {3'b000, 8'd1, 3'b000}) begin
      n_fail++; $display("FAIL reset_async: got %b want %b", rv, {3'b000, 8'd1, 3'b000});
    end
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #2;
    rv = {out_valid, out_last, out_owner, out_data, req0_ready, req1_ready, busy};
    n_tests++;
    if (rv !== {3'b000, 8'd1, 3'b000}) begin
      n_fail++; $display("FAIL reset_idle: got %b want %b", rv, {3'b000, 8'd1, 3'b000});
    end
    @(posedge clk); #1;
    m_cnt = 1; m_rr = 0;
  endtask

  task automatic test_single();
    int win, nb, exp; bit done;
    do_reset();
    request(1, 0, 3, 0, win);
    n_tests++;
    if (win !== 0) begin n_fail++; $display("FAIL single_win: got %0d want 0", win); end
    m_rr = 1;
    collect(0, done);
    nb = 0;
    foreach (log_q[i]) begin
      exp = (m_cnt + 2*nb) % MOD;
      n_tests++;
      if (log_q[i].v !== 1 || log_q[i].d !== WIDTH'(exp) || log_q[i].o !== 0 || log_q[i].l !== 1'(nb == 3) ||
          log_q[i].b !== 1 || log_q[i].rd0 !== 0 || log_q[i].rd1 !== 0) begin
        n_fail++;
        $display("FAIL single[%0d]: got v=%b d=%0d o=%b l=%b b=%b rdy=%b%b want v=1 d=%0d o=0 l=%0d b=1 rdy=00",
                 i, log_q[i].v, log_q[i].d, log_q[i].o, log_q[i].l, log_q[i].b, log_q[i].rd0, log_q[i].rd1, exp, nb == 3);
      end
      if (log_q[i].r) nb++;
    end
    n_tests++;
    if (!done || nb != 4) begin n_fail++; $display("FAIL single_len: got %0d beats done=%0d want 4", nb, done); end
    m_cnt = (m_cnt + 8) % MOD;
  endtask

  task automatic test_both();
    int win, nb, exp; bit done;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        n_tests++;
        if (out_valid !== 0) begin n_fail++; $display("FAIL both_gap%0d: got out_valid=%b want 0", k, out_valid); end
      end
      request(1, 1, 1, 1, win);
      n_tests++;
      if (win !== m_rr) begin n_fail++; $display("FAIL both_win%0d: got %0d want %0d", k, win, m_rr); end
      m_rr = 1 - m_rr;
      collect(0, done);
      nb = 0;
      foreach (log_q[i]) begin
        exp = (m_cnt + 2*nb) % MOD;
        n_tests++;
        if (log_q[i].v !== 1 || log_q[i].d !== WIDTH'(exp) || log_q[i].o !== 1'(k % 2) || log_q[i].l !== 1'(nb == 1)) begin
          n_fail++;
          $display("FAIL both%0d[%0d]: got v=%b d=%0d o=%b l=%b want v=1 d=%0d o=%0d l=%0d",
                   k, i, log_q[i].v, log_q[i].d, log_q[i].o, log_q[i].l, exp, k % 2, nb == 1);
        end
        if (log_q[i].r) nb++;
      end
      n_tests++;
      if (!done || nb != 2) begin n_fail++; $display("FAIL both_len%0d: got %0d beats want 2", k, nb); end
      m_cnt = (m_cnt + 4) % MOD;
    end
  endtask

  task automatic test_stall();
    int win, nb, exp, ew; bit done;
    ew = m_rr;
    request(1, 1, 2, 2, win);
    n_tests++;
    if (win !== ew) begin n_fail++; $display("FAIL stall_win: got %0d want %0d", win, ew); end
    m_rr = 1 - ew;
    collect(2, done);
    nb = 0;
    foreach (log_q[i]) begin
      exp = (m_cnt + 2*nb) % MOD;
      n_tests++;
      if (log_q[i].v !== 1 || log_q[i].d !== WIDTH'(exp) || log_q[i].o !== 1'(ew) || log_q[i].l !== 1'(nb == 2)) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b d=%0d o=%b l=%b want v=1 d=%0d o=%0d l=%0d",
                 i, log_q[i].v, log_q[i].d, log_q[i].o, log_q[i].l, exp, ew, nb == 2);
      end
      if (log_q[i].r) nb++;
    end
    n_tests++;
    if (!done || log_q.size() != 5) begin
      n_fail++; $display("FAIL stall_cycles: got %0d cycles want 5", log_q.size());
    end
    m_cnt = (m_cnt + 6) % MOD;
  endtask

  task automatic test_wrap();
    int win, nb, exp, len; bit done;
    do_reset();
    for (int k = 0; k < 128; k++) begin
      len = (k == 127) ? 2 : 0;
      request(0, 1, 0, len, win);
      collect(0, done);
      nb = 0;
      foreach (log_q[i]) begin
        exp = (m_cnt + 2*nb) % MOD;
        n_tests++;
        if (win !== 1 || log_q[i].d !== WIDTH'(exp) || log_q[i].d[0] !== 1 || log_q[i].o !== 1 || log_q[i].l !== 1'(nb == len)) begin
          n_fail++;
          $display("FAIL wrap%0d[%0d]: got win=%0d d=%0d o=%b l=%b want win=1 d=%0d o=1 l=%0d",
                   k, i, win, log_q[i].d, log_q[i].o, log_q[i].l, exp, nb == len);
        end
        if (log_q[i].r) nb++;
      end
      if (!done) begin n_tests++; n_fail++; $display("FAIL wrap_timeout%0d: got no last beat", k); end
      m_cnt = (m_cnt + 2*(len + 1)) % MOD;
    end
    m_rr = 0;
  endtask

  task automatic test_reset_mid();
    int win; bit done;
    logic [13:0] rv;
    do_reset();
    request(1, 0, 7, 0, win);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (out_data !== WIDTH'(1 + 2*i) || out_valid !== 1) begin
        n_fail++; $display("FAIL rstmid_beat%0d: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, 1 + 2*i);
      end
      @(posedge clk); #1;
    end
    #2 rst_n = 0;
    #1 rv = {out_valid, out_last, out_owner, out_data, req0_ready, req1_ready, busy};
    n_tests++;
    if (rv !== {3'b000, 8'd1, 3'b000}) begin
      n_fail++; $display("FAIL rstmid_async: got %b want %b", rv, {3'b000, 8'd1, 3'b000});
    end
    out_ready = 0;
    @(posedge clk); #1 rst_n = 1;
    m_cnt = 1; m_rr = 0;
    request(1, 0, 0, 0, win);
    collect(0, done);
    n_tests++;
    if (!done || log_q.size() != 1 || log_q[0].d !== WIDTH'(1) || log_q[0].l !== 1 || log_q[0].o !== 0) begin
      n_fail++; $display("FAIL rstmid_after: got d=%0d l=%b cycles=%0d want d=1 l=1 cycles=1",
                         log_q[0].d, log_q[0].l, log_q.size());
    end
    m_cnt = 3; m_rr = 1;
  endtask

  task automatic test_preempt();
    int win, nb, exp; bit done;
    do_reset();
    request(0, 1, 0, 15, win);
    n_tests++;
    if (win !== 1) begin n_fail++; $display("FAIL pre_win: got %0d want 1", win); end
    log_q.delete(); done = 0; out_ready = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i == 5) begin req0_valid = 1; req0_len = 0; end
      #1;
      log_q.push_back('{out_valid, out_ready, out_data, out_owner, out_last, busy, req0_ready, req1_ready});
      if (out_valid && out_last) done = 1;
      @(posedge clk); #1;
    end
    nb = 0;
    foreach (log_q[i]) begin
      exp = (m_cnt + 2*nb) % MOD;
      n_tests++;
      if (log_q[i].d !== WIDTH'(exp) || log_q[i].o !== 1 || log_q[i].l !== 1'(nb == 15) || log_q[i].rd0 !== 0) begin
        n_fail++;
        $display("FAIL pre[%0d]: got d=%0d o=%b l=%b rdy0=%b want d=%0d o=1 l=%0d rdy0=0",
                 i, log_q[i].d, log_q[i].o, log_q[i].l, log_q[i].rd0, exp, nb == 15);
      end
      nb++;
    end
    n_tests++;
    if (!done || nb != 16) begin n_fail++; $display("FAIL pre_len: got %0d beats want 16", nb); end
    m_cnt = (m_cnt + 32) % MOD;
    #1;
    n_tests++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      n_fail++; $display("FAIL pre_accept: got rdy=%b%b want rdy=10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    collect(0, done);
    n_tests++;
    if (!done || log_q[0].d !== WIDTH'(m_cnt) || log_q[0].o !== 0 || log_q[0].l !== 1) begin
      n_fail++; $display("FAIL pre_next: got d=%0d o=%b l=%b want d=%0d o=0 l=1",
                         log_q[0].d, log_q[0].o, log_q[0].l, m_cnt);
    end
    m_cnt = (m_cnt + 2) % MOD; m_rr = 1;
  endtask

  task automatic test_random();
    int win, nb, exp, ew, len, l0, l1; bit r0, r1, done;
    for (int k = 0; k < 30; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      l0 = $urandom_range(0, 15); l1 = $urandom_range(0, 15);
      ew  = (r0 && r1) ? m_rr : (r1 ? 1 : 0);
      len = ew ? l1 : l0;
      request(r0, r1, l0, l1, win);
      n_tests++;
      if (win !== ew) begin n_fail++; $display("FAIL rnd_win%0d: got %0d want %0d", k, win, ew); end
      m_rr = 1 - ew;
      collect(1, done);
      nb = 0;
      foreach (log_q[i]) begin
        exp = (m_cnt + 2*nb) % MOD;
        n_tests++;
        if (log_q[i].v !== 1 || log_q[i].d !== WIDTH'(exp) || log_q[i].o !== 1'(ew) ||
            log_q[i].l !== 1'(nb == len) || log_q[i].b !== 1) begin
          n_fail++;
          $display("FAIL rnd%0d[%0d]: got v=%b d=%0d o=%b l=%b b=%b want v=1 d=%0d o=%0d l=%0d b=1",
                   k, i, log_q[i].v, log_q[i].d, log_q[i].o, log_q[i].l, log_q[i].b, exp, ew, nb == len);
        end
        if (log_q[i].r) nb++;
      end
      n_tests++;
      if (!done || nb != len + 1) begin n_fail++; $display("FAIL rnd_len%0d: got %0d beats want %0d", k, nb, len + 1); end
      m_cnt = (m_cnt + 2*(len + 1)) % MOD;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_preempt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/odd_seq_sched.md
Name: odd_seq_sched

Overview:
- Shares one odd-value sequence generator between two requesters.
- Each requester asks for a burst of consecutive odd values.
- A round-robin arbiter picks a winner, and a small FSM streams the burst out through a valid/ready interface tagged with the owner.
- The generator state persists across bursts, so no odd value is issued twice until the sequence wraps.

Parameters:
- WIDTH, 8, width of the generated value.
- LEN_W, 4, width of the burst-length field; a burst has len+1 beats (1..2^LEN_W).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a burst request.
- req0_len  in  LEN_W  requester 0 burst length minus one.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 has a burst request.
- req1_len  in  LEN_W  requester 1 burst length minus one.
- req1_ready  out  1  requester 1 request accepted this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  current odd value.
- out_owner  out  1  index of the requester that owns the current burst.
- out_last  out  1  final beat of the burst.
- out_ready  in  1  sink accepts the beat.
- busy  out  1  a burst is in progress (state RUN).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, gen value cnt=1, rr pointer=0, remaining=0, owner=0.
  - Outputs out_valid=0, out_last=0, out_owner=0, out_data=1, req*_ready=0, busy=0.
- States: IDLE, RUN.
- IDLE:
  - Arbitrate only among requesters with req*_valid=1.
  - If exactly one is valid, it wins.
  - If both are valid, the winner is the rr pointer (0 to req0, 1 to req1).
  - reqN_ready=1 combinationally for the winner only, and only in IDLE.
  - The handshake completes in the same cycle (valid&&ready).
  - On accept: owner<=winner, remaining<=winner's len, rr pointer<=~winner, state<=RUN.
  - If neither is valid, stay in IDLE; the pointer is unchanged.
- RUN:
  - out_valid=1, out_data=cnt, out_owner=owner, out_last=(remaining==0), busy=1.
  - req0_ready=req1_ready=0; new requests wait.
  - Beat transfer on out_valid&&out_ready: cnt<=cnt+2 (mod 2^WIDTH), remaining<=remaining-1.
  - If out_last, state<=IDLE.
  - Stall (out_ready=0): out_data, out_owner, out_last and out_valid held stable; cnt and remaining are unchanged.
- Latency:
  - Request accepted at edge T; first beat is valid in the cycle after T.
  - At least one IDLE cycle between bursts (last beat at edge T, next accept at edge T+1 at earliest).
  - Max throughput is one beat per cycle within a burst.
- Arithmetic:
  - cnt is WIDTH bits and always odd, since it starts at 1 and the +2 wraps naturally (2^WIDTH-1 -> 1).
  - No saturation.
  - remaining is LEN_W bits.
- Requester request fields are sampled only at accept; changes at other times are ignored.
- Losing requester:
  - Its valid may stay high; it wins the next arbitration by round-robin.
  - Deassertion before acceptance is permitted, with no effect.
- out_ready is ignored in IDLE (out_valid=0).
- Reset mid-burst: immediate return to reset values, cnt=1, and the burst is discarded.

Test Plan:
- Reset, then req0_valid=1, req0_len=3, out_ready=1 constantly -> req0_ready pulses 1 cycle; beats 1,3,5,7 with owner=0, out_last on 7; busy high for 4 cycles.
- Both valid from reset, len=1 each, out_ready=1 -> req0 served first (1,3), one IDLE cycle, then req1 (5,7, owner=1). Repeat both -> req0 gets 9,11, req1 gets 13,15.
- Burst len=2, out_ready toggles 1,0,0,1,1 -> data held at 3 during both stall cycles; sequence 1,3,5 with no duplicates or skips; out_last only with 5.
- Wrap: run 127 single-beat bursts from req1, then one len=2 burst -> values ...,253,255,1,3 around the wrap; all outputs odd.
- Assert rst_n low mid-burst after beat 5 of a len=7 burst -> all outputs take reset values asynchronously; after release, a new req0 len=0 yields out_data=1 with out_last=1.
- req1 alone with len=15 -> 16 beats, 1..31; req0 raised mid-burst sees ready=0 until the return to IDLE, then is accepted with first beat 33.
